// File: rtl/hole_filler.sv
// Post-pass concealment: raster-scans the interpolated frame RAM and fills every
// hole pixel in place with the average of its left and above neighbours.
module hole_filler #(
  parameter logic [7:0] HOLE_VAL     = 8'h00,
  parameter logic [7:0] FILL_DEFAULT = 8'h80
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  height,
  input  logic [7:0]  width,
  output logic [15:0] addr,
  output logic        we,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        done,
  output logic [15:0] hole_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_RDUP = 3'd3,
    S_CALC = 3'd4,
    S_WR   = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [7:0]  w_lat, w_next, h_lat, h_next;
  logic [7:0]  x, x_next, y, y_next;
  logic [15:0] row_base, row_next;
  logic [7:0]  left, left_next, fill, fill_next;
  logic [15:0] cnt_next, addr_next, pix_addr;
  logic [8:0]  sum;
  logic        advance;

  always_comb begin
    state_next = state;
    w_next     = w_lat;
    h_next     = h_lat;
    x_next     = x;
    y_next     = y;
    row_next   = row_base;
    left_next  = left;
    fill_next  = fill;
    cnt_next   = hole_cnt;
    advance    = 1'b0;
    sum        = {1'b0, left} + {1'b0, din};

    case (state)
      S_IDLE: begin
        if (start) begin
          w_next     = width;
          h_next     = height;
          x_next     = 8'd0;
          y_next     = 8'd0;
          row_next   = 16'd0;
          cnt_next   = 16'd0;
          state_next = (width == 8'd0 || height == 8'd0) ? S_FIN : S_RD;
        end
      end
      S_RD: state_next = S_CHK;
      S_CHK: begin
        if (din != HOLE_VAL) begin
          left_next = din;
          advance   = 1'b1;
        end else if (y == 8'd0) begin
          fill_next  = (x == 8'd0) ? FILL_DEFAULT : left;
          state_next = S_WR;
        end else begin
          state_next = S_RDUP;
        end
      end
      S_RDUP: state_next = S_CALC;
      S_CALC: begin
        // din now holds the pixel above, which raster order guarantees is filled
        fill_next  = (x == 8'd0) ? din : 8'(sum >> 1);
        state_next = S_WR;
      end
      S_WR: begin
        left_next = fill;
        cnt_next  = (hole_cnt != 16'hFFFF) ? hole_cnt + 16'd1 : hole_cnt;
        advance   = 1'b1;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (advance) begin
      if (x == w_lat - 8'd1) begin
        if (y == h_lat - 8'd1) begin
          state_next = S_FIN;
        end else begin
          x_next     = 8'd0;
          y_next     = y + 8'd1;
          row_next   = row_base + {8'd0, w_lat};
          state_next = S_RD;
        end
      end else begin
        x_next     = x + 8'd1;
        state_next = S_RD;
      end
    end

    // Addresses are registered so they are on the bus during RD/RDUP/WR themselves
    pix_addr  = row_next + {8'd0, x_next};
    addr_next = addr;
    case (state_next)
      S_RD, S_WR: addr_next = pix_addr;
      S_RDUP:     addr_next = pix_addr - {8'd0, w_next};
      default:    addr_next = addr;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      w_lat    <= 8'd0;
      h_lat    <= 8'd0;
      x        <= 8'd0;
      y        <= 8'd0;
      row_base <= 16'd0;
      left     <= 8'd0;
      fill     <= 8'd0;
      hole_cnt <= 16'd0;
      addr     <= 16'd0;
      we       <= 1'b0;
      dout     <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      w_lat    <= w_next;
      h_lat    <= h_next;
      x        <= x_next;
      y        <= y_next;
      row_base <= row_next;
      left     <= left_next;
      fill     <= fill_next;
      hole_cnt <= cnt_next;
      addr     <= addr_next;
      we       <= (state_next == S_WR);
      if (state_next == S_WR) dout <= fill_next;
      busy     <= (state_next != S_IDLE) && (state_next != S_FIN);
      done     <= (state_next == S_FIN);
    end
  end

endmodule

// File: tb/tb_hole_filler.sv
// Bench for hole_filler: synchronous-read frame RAM model, directed frames from the
// concealment rules, randomized frames against a 2-D reference model, reset mid-scan.
module tb_hole_filler;

  logic        clk, rst_n, start;
  logic [7:0]  height, width, din, dout;
  logic [15:0] addr, hole_cnt;
  logic        we, busy, done;

  hole_filler dut (
    .CLK(clk), .reset(rst_n), .start(start), .height(height), .width(width),
    .addr(addr), .we(we), .dout(dout), .din(din), .busy(busy), .done(done),
    .hole_cnt(hole_cnt)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM: img is the picture the bench wants loaded, mem is the RAM contents
  logic [7:0]  img [256];
  logic [7:0]  mem [256];
  logic [7:0]  ref_pix [256];
  logic        ld_all;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (we) begin
      mem[addr[7:0]] <= dout;
    end
    din <= mem[addr[7:0]];
  end

  // Observation of DUT activity, sampled away from the active edge
  logic [23:0] wr_log [$];
  int          busy_cnt, done_cnt;
  initial begin
    busy_cnt = 0;
    done_cnt = 0;
  end
  always @(negedge clk) begin
    if (we) wr_log.push_back({addr, dout});
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Scoreboard
  logic [23:0] exp_q [$];
  int          tests, failed;
  int          exp_holes, exp_cycles;
  int          last_lat, last_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the frame in raster order applying the fill rules to a 2-D picture
  task automatic ref_model(input int w, input int h);
    int i, up, lf;
    logic [7:0] v;
    exp_q.delete();
    exp_holes  = 0;
    exp_cycles = 0;
    for (int k = 0; k < 256; k++) ref_pix[k] = img[k];
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        i = yy * w + xx;
        if (img[i] != 8'h00) begin
          exp_cycles += 2;
        end else begin
          if (yy == 0) begin
            v = (xx == 0) ? 8'h80 : ref_pix[i-1];
            exp_cycles += 3;
          end else begin
            up = int'(ref_pix[i-w]);
            lf = int'(ref_pix[i-1]);
            v  = (xx == 0) ? 8'(up) : 8'((lf + up) / 2);
            exp_cycles += 5;
          end
          ref_pix[i] = v;
          exp_holes++;
          exp_q.push_back({16'(i), v});
        end
      end
    end
  endtask

  // Driver: load img, start a scan, wait for done and score everything it wrote
  task automatic run_scan(input int w, input int h, input bit perturb);
    int  lat, base, b0, d0, n;
    bit  seen;
    logic [23:0] e;
    @(negedge clk);
    ld_all = 1'b1;
    @(negedge clk);
    ld_all = 1'b0;
    ref_model(w, h);
    base = wr_log.size();
    b0   = busy_cnt;
    d0   = done_cnt;
    width  = 8'(w);
    height = 8'(h);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("cnt_clear_on_start", 32'(hole_cnt), 32'd0);
    if (w > 0 && h > 0) begin
      check("first_addr", 32'(addr), 32'd0);
      check("busy_after_start", 32'(busy), 32'd1);
    end
    seen = done;
    while (!seen && lat < 3000) begin
      if (perturb && exp_cycles > 8 && lat == 5) begin
        start  = 1'b1;
        width  = ~8'(w);
        height = ~8'(h);
      end else if (perturb && lat == 6) begin
        start  = 1'b0;
        width  = 8'(w);
        height = 8'(h);
      end
      @(negedge clk);
      lat++;
      seen = done;
    end
    start  = 1'b0;
    width  = 8'(w);
    height = 8'(h);
    check("done_seen", 32'(seen), 32'd1);
    check("done_latency", 32'(lat), 32'(exp_cycles + 1));
    repeat (3) @(negedge clk);
    last_lat  = lat;
    last_busy = busy_cnt - b0;
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_cycles", 32'(last_busy), 32'(exp_cycles));
    check("hole_cnt", 32'(hole_cnt), 32'(exp_holes));
    n = wr_log.size() - base;
    check("write_count", 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      check("write_addr_data", 32'(wr_log[base+k]), 32'(e));
    end
    for (int k = 0; k < w * h; k++) check("frame_pixel", 32'(mem[k]), 32'(ref_pix[k]));
  endtask

  task automatic set_img(input int w, input int h, input int hole_pct);
    for (int k = 0; k < 256; k++) img[k] = 8'h55;
    for (int k = 0; k < w * h; k++)
      img[k] = ($urandom_range(0, 99) < hole_pct) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  initial begin
    int w, h, hmax, guard;
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    ld_all = 1'b0;
    width  = 8'd0;
    height = 8'd0;
    for (int k = 0; k < 256; k++) img[k] = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hole_cnt", 32'(hole_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4x2, no holes
    set_img(4, 2, 0);
    run_scan(4, 2, 1'b0);
    check("nohole_busy16", 32'(last_busy), 32'd16);

    // 4x2, hole at (1,1) with left 21 and above 10
    set_img(4, 2, 0);
    img[1] = 8'd10;
    img[4] = 8'd21;
    img[5] = 8'h00;
    run_scan(4, 2, 1'b0);
    check("avg_hole_addr5", 32'(mem[5]), 32'd15);
    check("avg_hole_cnt", 32'(hole_cnt), 32'd1);

    // holes at (0,0) and (2,0) with (1,0)=200
    set_img(4, 2, 0);
    img[0] = 8'h00;
    img[1] = 8'd200;
    img[2] = 8'h00;
    run_scan(4, 2, 1'b0);
    check("corner_default", 32'(mem[0]), 32'h80);
    check("row0_left_copy", 32'(mem[2]), 32'd200);

    // (0,1) hole under 7; three consecutive row-0 holes after 100
    set_img(5, 2, 0);
    img[0] = 8'd7;
    img[1] = 8'd100;
    img[2] = 8'h00;
    img[3] = 8'h00;
    img[4] = 8'h00;
    img[5] = 8'h00;
    run_scan(5, 2, 1'b0);
    check("above_only", 32'(mem[5]), 32'd7);
    check("chain_holes", 32'({mem[2], mem[3], mem[4]}), 32'({8'd100, 8'd100, 8'd100}));

    // zero-sized frames
    set_img(0, 0, 0);
    run_scan(0, 3, 1'b0);
    check("w0_latency", 32'(last_lat), 32'd1);
    run_scan(5, 0, 1'b0);
    check("h0_hole_cnt", 32'(hole_cnt), 32'd0);

    // randomized frames, one with start/size wiggled mid-scan
    for (int r = 0; r < 10; r++) begin
      w    = $urandom_range(1, 16);
      hmax = 256 / w;
      h    = $urandom_range(1, (hmax > 16) ? 16 : hmax);
      if (r == 0) begin
        w = 7;
        h = 5;
      end
      set_img(w, h, $urandom_range(10, 60));
      run_scan(w, h, r == 0);
    end

    // reset while the above pixel is being averaged
    set_img(4, 2, 0);
    img[5] = 8'h00;
    @(negedge clk);
    ld_all = 1'b1;
    @(negedge clk);
    ld_all = 1'b0;
    width  = 8'd4;
    height = 8'd2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (dut.state != 3'd4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reached_calc", 32'(guard < 100), 32'd1);
    check("busy_in_calc", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(4, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
